// File: rtl/spram_dma.sv
// Access controller in front of a single-port synchronous RAM: muxes the CPU
// port with a burst DMA channel that moves words between a stream and RAM.
module spram_dma #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_din,
  input  logic                  cpu_we,
  input  logic                  cpu_re,
  output logic                  cpu_hold,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_we,
  output logic                  ram_re,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  input  logic                  dma_start,
  input  logic                  dma_dir,
  input  logic [ADDR_WIDTH-1:0] dma_base,
  input  logic [LEN_WIDTH-1:0]  dma_len,
  output logic                  dma_busy,
  output logic                  dma_done,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                state, state_next;
  logic                  dir;
  logic [ADDR_WIDTH-1:0] addr;
  logic [LEN_WIDTH-1:0]  count;
  logic                  rd_inflight;

  logic [DATA_WIDTH-1:0] fifo_mem [2];
  logic                  wr_ptr, rd_ptr;
  logic [1:0]            fifo_cnt;

  logic                  beat_wr, beat_rd, dma_beat;
  logic                  push, pop;
  logic [1:0]            pending;

  assign push    = rd_inflight;
  assign m_valid = (fifo_cnt != 2'd0);
  assign m_data  = fifo_mem[rd_ptr];
  assign pop     = m_valid && m_ready;

  // The word leaving this cycle frees its slot, so a streaming reader can
  // sustain one word per cycle without the FIFO ever holding more than two.
  assign pending = fifo_cnt + {1'b0, rd_inflight} - {1'b0, pop};

  assign s_ready  = (state == RUN) && (count != '0) && !dir;
  assign beat_wr  = s_ready && s_valid;
  assign beat_rd  = (state == RUN) && (count != '0) && dir && (pending < 2'd2);
  assign dma_beat = beat_wr || beat_rd;

  assign dma_busy = (state != IDLE);
  assign dma_done = (state == DONE);
  assign cpu_hold = dma_beat && (cpu_we || cpu_re);

  always_comb begin
    ram_addr = cpu_addr;
    ram_din  = cpu_din;
    ram_we   = cpu_we;
    ram_re   = cpu_re;
    if (dma_beat) begin
      ram_addr = addr;
      ram_din  = s_data;
      ram_we   = beat_wr;
      ram_re   = beat_rd;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (dma_start) state_next = RUN;
      RUN:     if (count == '0) state_next = DRAIN;
      DRAIN:   if (!rd_inflight && (fifo_cnt == 2'd0)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      dir         <= 1'b0;
      addr        <= '0;
      count       <= '0;
      rd_inflight <= 1'b0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else begin
      state <= state_next;
      if ((state == IDLE) && dma_start) begin
        dir   <= dma_dir;
        addr  <= dma_base;
        count <= dma_len;
      end else if (dma_beat) begin
        addr  <= addr + ADDR_WIDTH'(1);
        count <= count - LEN_WIDTH'(1);
      end
      rd_inflight <= beat_rd;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  // RAM read data is valid the cycle after the DMA strobe; capture it then.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= ram_dout;
  end

endmodule

// File: tb/tb_spram_dma.sv
// Randomized bench for spram_dma: a behavioural RAM sits downstream and a
// reference memory image plus per-burst word lists predict every result.
module tb_spram_dma;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  cpu_addr;
  logic [15:0] cpu_din;
  logic        cpu_we, cpu_re, cpu_hold;
  logic [9:0]  ram_addr;
  logic [15:0] ram_din;
  logic        ram_we, ram_re;
  logic [15:0] ram_dout;
  logic        dma_start, dma_dir;
  logic [9:0]  dma_base;
  logic [10:0] dma_len;
  logic        dma_busy, dma_done;
  logic [15:0] s_data;
  logic        s_valid, s_ready;
  logic [15:0] m_data;
  logic        m_valid, m_ready;

  logic [15:0] ram_array [1024];
  logic [15:0] ref_mem   [1024];

  int vec_count  = 0;
  int miscompares = 0;

  spram_dma dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_we(cpu_we), .cpu_re(cpu_re),
    .cpu_hold(cpu_hold),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_re(ram_re),
    .ram_dout(ram_dout),
    .dma_start(dma_start), .dma_dir(dma_dir), .dma_base(dma_base), .dma_len(dma_len),
    .dma_busy(dma_busy), .dma_done(dma_done),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  // Downstream single-port synchronous RAM.
  always @(posedge clk) begin
    if (ram_we) ram_array[ram_addr] <= ram_din;
    if (ram_re) ram_dout <= ram_array[ram_addr];
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_mem_image(input string tag);
    int bad = 0;
    for (int i = 0; i < 1024; i++) if (ram_array[i] !== ref_mem[i]) bad++;
    checkOutput(tag, bad, 0);
  endtask

  task automatic cpu_write(input logic [9:0] a, input logic [15:0] d);
    cpu_addr = a; cpu_din = d; cpu_we = 1'b1;
    @(negedge clk);
    checkOutput("cpu_wr_hold", cpu_hold, 0);
    tick();
    cpu_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic cpu_read(input logic [9:0] a);
    cpu_addr = a; cpu_re = 1'b1;
    @(negedge clk);
    checkOutput("cpu_rd_hold", cpu_hold, 0);
    tick();
    cpu_re = 1'b0;
    @(negedge clk);
    checkOutput("cpu_rd_data", ram_dout, ref_mem[a]);
    tick();
  endtask

  task automatic launch(input logic d, input logic [9:0] b, input logic [10:0] l);
    dma_dir = d; dma_base = b; dma_len = l; dma_start = 1'b1;
    @(negedge clk);
    checkOutput("busy_before_start", dma_busy, 0);
    tick();
    dma_start = 1'b0;
    dma_dir   = 1'($urandom);
    dma_base  = 10'($urandom);
    dma_len   = 11'($urandom);
  endtask

  task automatic stream_write(input logic [9:0] base, input int len, input bit inject);
    logic [15:0] d [$];
    int idx = 0, beats = 0, we_cycles = 0, dones = 0, budget = 0;
    bit seen_done = 0, injected = 0;
    for (int i = 0; i < len; i++) d.push_back(16'($urandom));
    launch(1'b0, base, 11'(len));
    while (!seen_done && budget < 400) begin
      s_valid = (idx < len) && ($urandom_range(0, 3) != 0);
      s_data  = (idx < len) ? d[idx] : 16'($urandom);
      dma_start = 1'b0;
      if (inject && !injected && idx == 2) begin
        dma_start = 1'b1; dma_dir = 1'b1; dma_base = base + 10'h080; dma_len = 11'd2;
        injected = 1;
      end
      @(negedge clk);
      if (ram_we) we_cycles++;
      if (ram_we && s_ready && s_valid) begin
        checkOutput("wr_addr", ram_addr, 10'(base + 10'(beats)));
        checkOutput("wr_data", ram_din, d[idx]);
        beats++;
        idx++;
      end
      if (dma_done) begin dones++; seen_done = 1; end
      tick();
      budget++;
    end
    s_valid = 1'b0; dma_start = 1'b0;
    checkOutput("wr_done_seen", seen_done, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (dma_done) dones++;
      tick();
    end
    checkOutput("wr_beats", beats, len);
    checkOutput("wr_we_cycles", we_cycles, len);
    checkOutput("wr_done_pulses", dones, 1);
    checkOutput("wr_busy_after", dma_busy, 0);
    for (int i = 0; i < len; i++) ref_mem[10'(base + 10'(i))] = d[i];
    for (int i = 0; i < len; i++)
      checkOutput("wr_ram_word", ram_array[10'(base + 10'(i))], d[i]);
    check_mem_image("wr_mem_image");
  endtask

  task automatic stream_read(input logic [9:0] base, input int len, input bit patterned);
    logic [15:0] exp_q [$];
    logic [15:0] got_q [$];
    int pat [5] = '{1, 0, 0, 1, 1};
    int k = 0, reads = 0, max_out = 0, dones = 0;
    bit seen_done = 0;
    for (int i = 0; i < len; i++) exp_q.push_back(ref_mem[10'(base + 10'(i))]);
    launch(1'b1, base, 11'(len));
    while (!seen_done && k < 400) begin
      m_ready = patterned ? 1'(pat[k % 5]) : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (ram_re) reads++;
      if (m_valid && m_ready) got_q.push_back(m_data);
      if (reads - got_q.size() > max_out) max_out = reads - got_q.size();
      if (dma_done) begin seen_done = 1; dones++; end
      tick();
      k++;
    end
    checkOutput("rd_done_seen", seen_done, 1);
    m_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      if (m_valid) got_q.push_back(m_data);
      if (dma_done) dones++;
      tick();
    end
    m_ready = 1'b0;
    checkOutput("rd_ram_reads", reads, len);
    checkOutput("rd_word_count", got_q.size(), len);
    checkOutput("rd_max_outstanding_ok", (max_out <= 2), 1);
    checkOutput("rd_done_pulses", dones, 1);
    for (int i = 0; i < len && i < got_q.size(); i++)
      checkOutput("rd_word", got_q[i], exp_q[i]);
  endtask

  task automatic collision();
    logic [15:0] d [3];
    logic [15:0] c0, old;
    int budget = 0;
    bit seen_done = 0;
    for (int i = 0; i < 3; i++) d[i] = 16'($urandom);
    c0  = 16'($urandom) | 16'h0001;
    old = ref_mem[10'h100];
    if (c0 == old) c0 = ~old;
    launch(1'b0, 10'h040, 11'd3);
    s_valid = 1'b1; s_data = d[0];
    cpu_we = 1'b1; cpu_addr = 10'h100; cpu_din = c0;
    @(negedge clk);
    checkOutput("col_hold_on_beat", cpu_hold, 1);
    checkOutput("col_dma_addr", ram_addr, 10'h040);
    tick();
    checkOutput("col_ram_untouched", ram_array[10'h100], old);
    s_valid = 1'b0;
    @(negedge clk);
    checkOutput("col_hold_retry", cpu_hold, 0);
    checkOutput("col_cpu_addr", ram_addr, 10'h100);
    tick();
    cpu_we = 1'b0;
    ref_mem[10'h100] = c0;
    checkOutput("col_ram_written", ram_array[10'h100], c0);
    for (int i = 1; i < 3; i++) begin
      s_valid = 1'b1; s_data = d[i];
      @(negedge clk);
      tick();
    end
    s_valid = 1'b0;
    while (!seen_done && budget < 20) begin
      @(negedge clk);
      if (dma_done) seen_done = 1;
      tick();
      budget++;
    end
    checkOutput("col_done_seen", seen_done, 1);
    for (int i = 0; i < 3; i++) ref_mem[10'h040 + 10'(i)] = d[i];
    check_mem_image("col_mem_image");
  endtask

  task automatic zero_length();
    int acc = 0;
    dma_dir = 1'($urandom); dma_base = 10'($urandom); dma_len = 11'd0; dma_start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (ram_we || ram_re) acc++;
      checkOutput($sformatf("zero_done_k%0d", k), dma_done, (k == 3));
      tick();
      dma_start = 1'b0;
    end
    checkOutput("zero_no_access", acc, 0);
    checkOutput("zero_busy_after", dma_busy, 0);
  endtask

  task automatic reset_mid_burst();
    int reads = 0, budget = 0, dones = 0, late_reads = 0;
    m_ready = 1'b0;
    launch(1'b1, 10'h080, 11'd8);
    while (reads < 2 && budget < 20) begin
      @(negedge clk);
      if (ram_re) reads++;
      tick();
      budget++;
    end
    checkOutput("rst_two_reads", reads, 2);
    rst = 1'b1;
    @(negedge clk);
    if (dma_done) dones++;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_m_valid", m_valid, 0);
    checkOutput("rst_busy", dma_busy, 0);
    tick();
    for (int k = 0; k < 6; k++) begin
      m_ready = 1'($urandom);
      @(negedge clk);
      if (dma_done) dones++;
      if (ram_re) late_reads++;
      if (m_valid) dones++;
      tick();
    end
    m_ready = 1'b0;
    checkOutput("rst_no_done_or_data", dones, 0);
    checkOutput("rst_no_late_reads", late_reads, 0);
  endtask

  initial begin
    rst = 1'b1;
    cpu_addr = '0; cpu_din = '0; cpu_we = 1'b0; cpu_re = 1'b0;
    dma_start = 1'b0; dma_dir = 1'b0; dma_base = '0; dma_len = '0;
    s_data = '0; s_valid = 1'b0; m_ready = 1'b0;
    tick();
    tick();
    @(negedge clk);
    checkOutput("reset_busy", dma_busy, 0);
    checkOutput("reset_done", dma_done, 0);
    checkOutput("reset_m_valid", m_valid, 0);
    checkOutput("reset_s_ready", s_ready, 0);
    checkOutput("reset_ram_we", ram_we, 0);
    checkOutput("reset_ram_re", ram_re, 0);
    checkOutput("reset_cpu_hold", cpu_hold, 0);
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 1024; i++) cpu_write(10'(i), 16'($urandom));
    check_mem_image("preload_image");
    for (int i = 0; i < 4; i++) cpu_read(10'($urandom));

    stream_write(10'h010, 4, 1'b0);
    collision();
    for (int i = 0; i < 3; i++) cpu_write(10'h020 + 10'(i), 16'hB100 + 16'($urandom_range(0, 255)));
    stream_read(10'h020, 3, 1'b1);
    stream_write(10'h3FE, 4, 1'b0);
    zero_length();
    stream_write(10'h200, 6, 1'b1);
    reset_mid_burst();
    stream_read(10'h3FA, 10, 1'b0);
    stream_write(10'($urandom), 9, 1'b0);
    stream_read(10'($urandom), 12, 1'b0);
    for (int i = 0; i < 4; i++) cpu_read(10'($urandom));
    check_mem_image("final_mem_image");

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
